rv_alu_arb: RTL and testbench

- Two-requester arbiter that shares one combinational ALU instance. Typical requesters are the execute stage and the address/CSR side path.
- Accepts operation requests over a valid/ready handshake and drives the shared ALU's operand/select ports.
- Registers each result into a one-entry response slot per requester and returns it over a second valid/ready handshake.
- Throughput: one ALU operation per cycle in total. Latency: 1 cycle from grant to response valid.

---
 rtl/rv_alu_arb.sv | 109 ++++++++++
 tb/tb_rv_alu_arb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_alu_arb.sv
// Two-requester arbiter in front of one shared combinational ALU with a one-entry response slot per requester.
// Latency 1 cycle from grant to response; a full, undrained slot blocks its own requester only.
module rv_alu_arb #(
    parameter int XLEN  = 64,
    parameter bit RR_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [XLEN-1:0] req0_op1_i,
    input  logic [XLEN-1:0] req0_op2_i,
    input  logic [3:0]      req0_sel_i,
    input  logic            req0_32b_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [XLEN-1:0] req1_op1_i,
    input  logic [XLEN-1:0] req1_op2_i,
    input  logic [3:0]      req1_sel_i,
    input  logic            req1_32b_i,
    output logic            rsp0_valid_o,
    input  logic            rsp0_ready_i,
    output logic [XLEN-1:0] rsp0_result_o,
    output logic            rsp1_valid_o,
    input  logic            rsp1_ready_i,
    output logic [XLEN-1:0] rsp1_result_o,
    output logic [XLEN-1:0] alu_op1_o,
    output logic [XLEN-1:0] alu_op2_o,
    output logic [3:0]      alu_sel_o,
    output logic            alu_32b_o,
    input  logic [XLEN-1:0] alu_result_i,
    output logic [1:0]      gnt_o
);

    logic            r_rsp0_vld;
    logic            r_rsp1_vld;
    logic [XLEN-1:0] r_rsp0_res;
    logic [XLEN-1:0] r_rsp1_res;
    logic            r_ptr;

    logic w_elig0;
    logic w_elig1;
    logic w_pick1;
    logic w_gnt0;
    logic w_gnt1;

    // A slot draining this cycle can be refilled in the same cycle.
    always_comb begin
        w_elig0 = req0_valid_i & (~r_rsp0_vld | rsp0_ready_i);
        w_elig1 = req1_valid_i & (~r_rsp1_vld | rsp1_ready_i);
        w_pick1 = RR_EN & r_ptr;
        w_gnt0  = w_elig0 & ~(w_elig1 & w_pick1);
        w_gnt1  = w_elig1 & ~(w_elig0 & ~w_pick1);
    end

    always_comb begin
        alu_op1_o = '0;
        alu_op2_o = '0;
        alu_sel_o = 4'b0000;
        alu_32b_o = 1'b0;
        if (w_gnt0) begin
            alu_op1_o = req0_op1_i;
            alu_op2_o = req0_op2_i;
            alu_sel_o = req0_sel_i;
            alu_32b_o = req0_32b_i;
        end else if (w_gnt1) begin
            alu_op1_o = req1_op1_i;
            alu_op2_o = req1_op2_i;
            alu_sel_o = req1_sel_i;
            alu_32b_o = req1_32b_i;
        end
    end

    assign gnt_o         = {w_gnt1, w_gnt0};
    assign req0_ready_o  = w_gnt0;
    assign req1_ready_o  = w_gnt1;
    assign rsp0_valid_o  = r_rsp0_vld;
    assign rsp1_valid_o  = r_rsp1_vld;
    assign rsp0_result_o = r_rsp0_res;
    assign rsp1_result_o = r_rsp1_res;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rsp0_vld <= 1'b0;
            r_rsp1_vld <= 1'b0;
            r_rsp0_res <= '0;
            r_rsp1_res <= '0;
            r_ptr      <= 1'b0;
        end else begin
            if (w_gnt0) begin
                r_rsp0_vld <= 1'b1;
                r_rsp0_res <= alu_result_i;
            end else if (rsp0_ready_i) begin
                r_rsp0_vld <= 1'b0;
            end
            if (w_gnt1) begin
                r_rsp1_vld <= 1'b1;
                r_rsp1_res <= alu_result_i;
            end else if (rsp1_ready_i) begin
                r_rsp1_vld <= 1'b0;
            end
            // Pointer points at whoever lost, so it is preferred next time.
            if (RR_EN && (w_gnt0 || w_gnt1)) begin
                r_ptr <= w_gnt0;
            end
        end
    end

endmodule

// File: tb/tb_rv_alu_arb.sv
// Bench for rv_alu_arb: round-robin instance under scoreboard, fixed-priority instance for priority checks.
module tb_rv_alu_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [63:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [3:0]  req0_sel = '0, req1_sel = '0;
    logic        req0_32b = 1'b0, req1_32b = 1'b0;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_32b;
    logic [63:0] rsp0_result, rsp1_result, alu_op1, alu_op2, alu_result;
    logic [3:0]  alu_sel;
    logic [1:0]  gnt;

    logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_alu_32b;
    logic [63:0] fp_rsp0_result, fp_rsp1_result, fp_alu_op1, fp_alu_op2, fp_alu_result;
    logic [3:0]  fp_alu_sel;
    logic [1:0]  fp_gnt;

    int n_pass = 0;
    int n_chk  = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] sel, input logic w32);
        logic [63:0] r;
        case (sel)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0111: r = a & b;
            4'b0110: r = a | b;
            4'b0100: r = a ^ b;
            default: r = 64'd0;
        endcase
        if (w32) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    assign alu_result    = alu_f(alu_op1, alu_op2, alu_sel, alu_32b);
    assign fp_alu_result = alu_f(fp_alu_op1, fp_alu_op2, fp_alu_sel, fp_alu_32b);

    rv_alu_arb #(.XLEN(64), .RR_EN(1'b1)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op1_i(req0_op1),
        .req0_op2_i(req0_op2), .req0_sel_i(req0_sel), .req0_32b_i(req0_32b),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op1_i(req1_op1),
        .req1_op2_i(req1_op2), .req1_sel_i(req1_sel), .req1_32b_i(req1_32b),
        .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_result_o(rsp0_result),
        .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_result_o(rsp1_result),
        .alu_op1_o(alu_op1), .alu_op2_o(alu_op2), .alu_sel_o(alu_sel), .alu_32b_o(alu_32b),
        .alu_result_i(alu_result), .gnt_o(gnt)
    );

    rv_alu_arb #(.XLEN(64), .RR_EN(1'b0)) dut_fp (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(fp_req0_ready), .req0_op1_i(req0_op1),
        .req0_op2_i(req0_op2), .req0_sel_i(req0_sel), .req0_32b_i(req0_32b),
        .req1_valid_i(req1_valid), .req1_ready_o(fp_req1_ready), .req1_op1_i(req1_op1),
        .req1_op2_i(req1_op2), .req1_sel_i(req1_sel), .req1_32b_i(req1_32b),
        .rsp0_valid_o(fp_rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_result_o(fp_rsp0_result),
        .rsp1_valid_o(fp_rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_result_o(fp_rsp1_result),
        .alu_op1_o(fp_alu_op1), .alu_op2_o(fp_alu_op2), .alu_sel_o(fp_alu_sel), .alu_32b_o(fp_alu_32b),
        .alu_result_i(fp_alu_result), .gnt_o(fp_gnt)
    );

    // Scoreboard: push on grant (from the requester's own fields), pop on response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid && rsp0_ready) begin
                n_chk++;
                if (q0.size() == 0) $display("FAIL sb_rsp0: got %h, expected no response", rsp0_result);
                else begin
                    logic [63:0] e;
                    e = q0.pop_front();
                    if (rsp0_result !== e) $display("FAIL sb_rsp0: got %h, expected %h", rsp0_result, e);
                    else n_pass++;
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                n_chk++;
                if (q1.size() == 0) $display("FAIL sb_rsp1: got %h, expected no response", rsp1_result);
                else begin
                    logic [63:0] e;
                    e = q1.pop_front();
                    if (rsp1_result !== e) $display("FAIL sb_rsp1: got %h, expected %h", rsp1_result, e);
                    else n_pass++;
                end
            end
            if (gnt[0]) q0.push_back(alu_f(req0_op1, req0_op2, req0_sel, req0_32b));
            if (gnt[1]) q1.push_back(alu_f(req1_op1, req1_op2, req1_sel, req1_32b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        q0.delete();
        q1.delete();
        rst_n = 1'b1;
    endtask

    task automatic rand_req0();
        logic [3:0] sels [5] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100};
        req0_op1 = {$urandom, $urandom};
        req0_op2 = {$urandom, $urandom};
        req0_sel = sels[$urandom_range(0, 4)];
        req0_32b = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_req1();
        logic [3:0] sels [5] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100};
        req1_op1 = {$urandom, $urandom};
        req1_op2 = {$urandom, $urandom};
        req1_sel = sels[$urandom_range(0, 4)];
        req1_32b = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        tick();
        n_chk++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) $display("FAIL reset_vld: got %b, expected 00", {rsp0_valid, rsp1_valid});
        else n_pass++;
        n_chk++;
        if (rsp0_result !== 64'd0 || rsp1_result !== 64'd0)
            $display("FAIL reset_res: got %h/%h, expected 0/0", rsp0_result, rsp1_result);
        else n_pass++;
        n_chk++;
        if (gnt !== 2'b00 || alu_op1 !== 64'd0 || alu_sel !== 4'd0)
            $display("FAIL idle_drive: gnt %b op1 %h sel %h, expected 00/0/0", gnt, alu_op1, alu_sel);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        req0_valid = 1'b1; req0_op1 = 64'd5; req0_op2 = 64'd3; req0_sel = 4'b0000; req0_32b = 1'b0;
        #1;
        n_chk++;
        if (req0_ready !== 1'b1 || gnt !== 2'b01 || alu_op1 !== 64'd5)
            $display("FAIL add_grant: ready %b gnt %b op1 %h, expected 1/01/5", req0_ready, gnt, alu_op1);
        else n_pass++;
        tick();
        req0_valid = 1'b0;
        #1;
        n_chk++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 64'h8)
            $display("FAIL add_rsp: valid %b result %h, expected 1/8", rsp0_valid, rsp0_result);
        else n_pass++;
        tick();
        n_chk++;
        if (rsp0_valid !== 1'b0 || rsp0_result !== 64'h8)
            $display("FAIL add_drain: valid %b result %h, expected 0/8", rsp0_valid, rsp0_result);
        else n_pass++;
    endtask

    task automatic test_32b();
        req1_valid = 1'b1; req1_op1 = 64'h7FFF_FFFF; req1_op2 = 64'd1; req1_sel = 4'b0000; req1_32b = 1'b1;
        #1;
        n_chk++;
        if (gnt !== 2'b10 || alu_32b !== 1'b1)
            $display("FAIL w32_grant: gnt %b 32b %b, expected 10/1", gnt, alu_32b);
        else n_pass++;
        tick();
        req1_valid = 1'b0;
        #1;
        n_chk++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 64'hFFFF_FFFF_8000_0000)
            $display("FAIL w32_rsp: valid %b result %h, expected 1/ffffffff80000000", rsp1_valid, rsp1_result);
        else n_pass++;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        rand_req0(); rand_req1();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_chk++;
            if (gnt !== exp) $display("FAIL rr_gnt[%0d]: got %b, expected %b", i, gnt, exp);
            else n_pass++;
            tick();
            if (exp[0]) rand_req0(); else rand_req1();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        rand_req0(); rand_req1();
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if (req0_ready !== 1'b0 || gnt !== 2'b10)
                $display("FAIL stall[%0d]: ready0 %b gnt %b, expected 0/10", i, req0_ready, gnt);
            else n_pass++;
            tick();
            rand_req1();
        end
        rsp0_ready = 1'b1;
        #1;
        n_chk++;
        if (req0_ready !== 1'b1 || gnt !== 2'b01)
            $display("FAIL refill_grant: ready0 %b gnt %b, expected 1/01", req0_ready, gnt);
        else n_pass++;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        n_chk++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== alu_f(req0_op1, req0_op2, req0_sel, req0_32b))
            $display("FAIL refill_rsp: valid %b result %h, expected 1/%h", rsp0_valid, rsp0_result,
                     alu_f(req0_op1, req0_op2, req0_sel, req0_32b));
        else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        rand_req0(); rand_req1();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++;
            if (fp_gnt !== 2'b01) $display("FAIL fp_gnt[%0d]: got %b, expected 01", i, fp_gnt);
            else n_pass++;
            tick();
        end
        req0_valid = 1'b0;
        #1;
        n_chk++;
        if (fp_gnt !== 2'b10) $display("FAIL fp_drop: got %b, expected 10", fp_gnt);
        else n_pass++;
        tick();
        req1_valid = 1'b0;
        #1;
        n_chk++;
        if (fp_rsp1_valid !== 1'b1 || fp_rsp1_result !== alu_f(req1_op1, req1_op2, req1_sel, req1_32b))
            $display("FAIL fp_rsp1: valid %b result %h, expected 1/%h", fp_rsp1_valid, fp_rsp1_result,
                     alu_f(req1_op1, req1_op2, req1_sel, req1_32b));
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        rand_req0(); rand_req1();
        req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        #1;
        n_chk++;
        if ({rsp1_valid, rsp0_valid} !== 2'b11) $display("FAIL mid_full: got %b, expected 11", {rsp1_valid, rsp0_valid});
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({rsp1_valid, rsp0_valid} !== 2'b00) $display("FAIL mid_async: got %b, expected 00", {rsp1_valid, rsp0_valid});
        else n_pass++;
        q0.delete();
        q1.delete();
        rand_req0(); rand_req1();
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (gnt !== 2'b01) $display("FAIL mid_first_gnt: got %b, expected 01", gnt);
        else n_pass++;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_drain();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();
        n_chk++;
        if (q0.size() != 0 || q1.size() != 0)
            $display("FAIL sb_empty: pending %0d/%0d, expected 0/0", q0.size(), q1.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_32b();
        test_round_robin();
        test_stall();
        test_fixed_priority();
        test_reset_mid();
        test_drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
